sram_bus_arbiter: RTL and testbench

Arbitrates the instruction-fetch port and the data-memory port onto one shared sram-like bus. It sequences exactly one outstanding transaction at a time: grant, address handshake, then data handshake. It routes `data_ok`/`rdata` back to the owning requester. It sits between the IF/EX/MEM stages and the single memory bridge, replacing the separate inst/data SRAM ports.

---
 rtl/sram_bus_pkg.sv | 24 ++
 rtl/sram_arb_grant.sv | 64 ++++++
 rtl/sram_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_pkg.sv
// Shared types for the instruction/data SRAM bus arbiter.
// Latency: none (types only).
// Backpressure: none (types only).
// Contents: FSM state encoding, transaction owner encoding, access size codes.
package sram_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

endpackage

// File: rtl/sram_arb_grant.sv
// Grant selector between the instruction and data requesters.
// Latency: combinational grant; the round-robin pointer updates on the clock after a grant.
// Backpressure: grant is only produced while grant_en is high; otherwise both bits stay 0.
// Ports: inst_req/data_req requests, grant_en enables a decision, grant is one-hot
//        (bit 0 = INST, bit 1 = DATA). clk/reset exist only in the round-robin build.
// Config: SRAM_ARB_RR_EN selects round-robin; undefined gives fixed data-over-inst priority.
module sram_arb_grant
  import sram_bus_pkg::*;
(
`ifdef SRAM_ARB_RR_EN
  input  logic       clk,
  input  logic       reset,
`endif
  input  logic       inst_req,
  input  logic       data_req,
  input  logic       grant_en,
  output logic [1:0] grant
);

`ifdef SRAM_ARB_RR_EN
  owner_e     ptr_q, ptr_d;
  logic [1:0] gnt;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (grant_en) begin
      if (inst_req && data_req) begin
        gnt = (ptr_q == OWN_DATA) ? 2'b10 : 2'b01;
      end else begin
        gnt = {data_req, inst_req};
      end
      // The pointer always moves to the port that was not just served.
      if (gnt[1]) begin
        ptr_d = OWN_INST;
      end else if (gnt[0]) begin
        ptr_d = OWN_DATA;
      end
    end
  end

  assign grant = gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= OWN_INST;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    grant = 2'b00;
    if (grant_en) begin
      if (data_req) begin
        grant = 2'b10;
      end else if (inst_req) begin
        grant = 2'b01;
      end
    end
  end
`endif

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like bus between the instruction-fetch and data-memory ports,
// one outstanding transaction at a time (IDLE -> ADDR -> DATA).
// Latency: bus_req rises the cycle after a request is seen in IDLE; addr_ok/data_ok are
//          combinational from bus_addr_ok/bus_data_ok; minimum 3 cycles per transaction.
// Backpressure: a losing or late requester holds req until its addr_ok; the bridge stalls
//          by withholding bus_addr_ok / bus_data_ok.
// Ports: inst_* and data_* requester ports (req/wr/size/addr/wdata/wstrb in,
//        addr_ok/data_ok/rdata out); bus_* registered request to the bridge plus its
//        addr_ok/data_ok/rdata handshakes.
// Config: SRAM_ARB_RR_EN enables round-robin arbitration (default: data port has priority).
module sram_bus_arbiter
  import sram_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wstrb,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [1:0]          bus_size,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int STRB_W = DATA_W / 8;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                grant_en;
  logic [1:0]          grant;

  assign grant_en = (state_q == ST_IDLE) && (inst_req || data_req);

  sram_arb_grant u_grant (
`ifdef SRAM_ARB_RR_EN
    .clk      (clk),
    .reset    (reset),
`endif
    .inst_req (inst_req),
    .data_req (data_req),
    .grant_en (grant_en),
    .grant    (grant)
  );

  // Capture the winner's request so the bus stays stable for the whole address phase,
  // even if the requester misbehaves and drops req early.
  always_comb begin
    owner_d = owner_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    if (grant[1]) begin
      owner_d = OWN_DATA;
      wr_d    = data_wr;
      size_d  = data_size;
      addr_d  = data_addr;
      wdata_d = data_wdata;
      wstrb_d = data_wstrb;
    end else if (grant[0]) begin
      owner_d = OWN_INST;
      wr_d    = inst_wr;
      size_d  = inst_size;
      addr_d  = inst_addr;
      wdata_d = inst_wdata;
      wstrb_d = inst_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_INST;
      wr_q    <= 1'b0;
      size_q  <= SIZE_B;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      owner_q <= owner_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. bus_data_ok outside DATA is ignored; writes also wait for it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_en)    state_d = ST_ADDR;
      ST_ADDR: if (bus_addr_ok) state_d = ST_DATA;
      ST_DATA: if (bus_data_ok) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Outputs. Handshake pulses are steered only to the current owner.
  always_comb begin
    bus_req      = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state_q)
      ST_ADDR: begin
        bus_req      = 1'b1;
        inst_addr_ok = bus_addr_ok && (owner_q == OWN_INST);
        data_addr_ok = bus_addr_ok && (owner_q == OWN_DATA);
      end
      ST_DATA: begin
        inst_data_ok = bus_data_ok && (owner_q == OWN_INST);
        data_data_ok = bus_data_ok && (owner_q == OWN_DATA);
      end
      default: ;
    endcase
  end

  assign bus_wr     = wr_q;
  assign bus_size   = size_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign bus_wstrb  = wstrb_q;
  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Randomized bench: requesters and a bridge are driven from a transaction-level model;
// every cycle the expected bus/handshake picture is queued and a monitor compares it.
module tb_sram_bus_arbiter;

  localparam int NCYC = 4000;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        bus_req;
    req_t        lat;
    logic        iaok;
    logic        daok;
    logic        idok;
    logic        ddok;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_wstrb   (inst_wstrb),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_wstrb   (data_wstrb),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_size     (bus_size),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_wstrb    (bus_wstrb),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req,
                     input logic [31:0] cyc);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  function automatic req_t rnd_req();
    req_t r;
    r.wr    = 1'($urandom_range(0, 1));
    r.size  = 2'($urandom_range(0, 2));
    r.addr  = $urandom;
    r.wdata = $urandom;
    r.wstrb = 4'($urandom_range(0, 15));
    return r;
  endfunction

  // Bridge stall before it answers: mostly immediate, sometimes a long 5-cycle stall.
  function automatic int rnd_stall();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 5) return 0;
    if (r < 8) return int'($urandom_range(1, 2));
    return 5;
  endfunction

  // Monitor: one expectation per driven cycle, checked after inputs have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("bus_req",      64'(bus_req),      64'(e.bus_req),   e.cyc);
        chk("bus_wr",       64'(bus_wr),       64'(e.lat.wr),    e.cyc);
        chk("bus_size",     64'(bus_size),     64'(e.lat.size),  e.cyc);
        chk("bus_addr",     64'(bus_addr),     64'(e.lat.addr),  e.cyc);
        chk("bus_wdata",    64'(bus_wdata),    64'(e.lat.wdata), e.cyc);
        chk("bus_wstrb",    64'(bus_wstrb),    64'(e.lat.wstrb), e.cyc);
        chk("inst_addr_ok", 64'(inst_addr_ok), 64'(e.iaok),      e.cyc);
        chk("data_addr_ok", 64'(data_addr_ok), 64'(e.daok),      e.cyc);
        chk("inst_data_ok", 64'(inst_data_ok), 64'(e.idok),      e.cyc);
        chk("data_data_ok", 64'(data_data_ok), 64'(e.ddok),      e.cyc);
        if (e.idok) chk("inst_rdata", 64'(inst_rdata), 64'(e.rdata), e.cyc);
        if (e.ddok) chk("data_rdata", 64'(data_rdata), 64'(e.rdata), e.cyc);
      end
    end
  end

  // Driver + transaction-level reference model.
  // phase: 0 = bus free, 1 = waiting for bridge address accept, 2 = waiting for data.
  initial begin
    int          phase;
    int          stall;
    bit          owner;   // 0 = instruction, 1 = data
    bit          ptr;     // round-robin preference, 0 = instruction
    bit          win;
    bit          inst_pend, data_pend, do_rst, aok, dok;
    req_t        inst_cur, data_cur, lat;
    logic [31:0] rd;
    exp_t        e;
    int          n_txn;

    phase = 0; stall = 0; owner = 1'b0; ptr = 1'b0; n_txn = 0;
    inst_pend = 1'b0; data_pend = 1'b0;
    inst_cur = '0; data_cur = '0; lat = '0;
    reset = 1'b1;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = '0; inst_addr = '0; inst_wdata = '0; inst_wstrb = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0; data_wdata = '0; data_wstrb = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);

    for (int n = 0; n < NCYC; n++) begin
      @(negedge clk);

      // Occasional reset while the data phase is outstanding.
      do_rst = (phase == 2) && ($urandom_range(0, 99) == 0);
      reset  = do_rst;

      if (!inst_pend && $urandom_range(0, 99) < 30) begin
        inst_pend = 1'b1;
        inst_cur  = rnd_req();
      end
      if (!data_pend && $urandom_range(0, 99) < 25) begin
        data_pend = 1'b1;
        data_cur  = rnd_req();
      end

      inst_req = inst_pend; inst_wr = inst_cur.wr; inst_size = inst_cur.size;
      inst_addr = inst_cur.addr; inst_wdata = inst_cur.wdata; inst_wstrb = inst_cur.wstrb;
      data_req = data_pend; data_wr = data_cur.wr; data_size = data_cur.size;
      data_addr = data_cur.addr; data_wdata = data_cur.wdata; data_wstrb = data_cur.wstrb;

      // Illegal early drop by the granted requester; the latched transaction must persist.
      if (phase == 1 && $urandom_range(0, 15) == 0) begin
        if (owner) begin
          data_req = 1'b0; data_addr = $urandom;
        end else begin
          inst_req = 1'b0; inst_addr = $urandom;
        end
      end

      aok = 1'b0;
      dok = 1'b0;
      if (!do_rst) begin
        if (phase == 1) begin
          if (stall == 0) aok = 1'b1; else stall--;
          if ($urandom_range(0, 7) == 0) dok = 1'b1;    // protocol violation, must be ignored
        end else if (phase == 2) begin
          if (stall == 0) dok = 1'b1; else stall--;
        end else if ($urandom_range(0, 9) == 0) begin
          dok = 1'b1;                                   // spurious data_ok while idle
        end
      end
      rd          = $urandom;
      bus_addr_ok = aok;
      bus_data_ok = dok;
      bus_rdata   = rd;

      e.cyc     = 32'(n);
      e.bus_req = (phase == 1);
      e.lat     = lat;
      e.iaok    = (phase == 1) && aok && !owner;
      e.daok    = (phase == 1) && aok && owner;
      e.idok    = (phase == 2) && dok && !owner;
      e.ddok    = (phase == 2) && dok && owner;
      e.rdata   = rd;
      exp_q.push_back(e);

      if (do_rst) begin
        phase = 0; lat = '0; ptr = 1'b0; owner = 1'b0;
      end else if (phase == 0) begin
        if (inst_pend || data_pend) begin
`ifdef SRAM_ARB_RR_EN
          win = (inst_pend && data_pend) ? ptr : data_pend;
`else
          win = data_pend;
`endif
          ptr   = !win;
          owner = win;
          lat   = win ? data_cur : inst_cur;
          phase = 1;
          stall = rnd_stall();
        end
      end else if (phase == 1) begin
        if (aok) begin
          if (owner) data_pend = 1'b0; else inst_pend = 1'b0;
          phase = 2;
          stall = rnd_stall();
        end
      end else begin
        if (dok) begin
          phase = 0;
          n_txn++;
        end
      end
    end

    @(negedge clk);
    #2;
    if (n_txn < 100) begin
      n_err++;
      $display("FAIL txn_count actual=%0d required>=100", n_txn);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
